// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues in-order fetches over req/gnt/rvalid,
// buffers up to two returned instructions and drives the IF/ID register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        next_pc_sel,
    input  logic [31:0] jb_pc,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_gnt,
    input  logic        im_rvalid,
    input  logic [31:0] im_rdata,
    output logic [31:0] D_pc,
    output logic [31:0] D_inst,
    output logic        D_valid
);

    localparam logic [2:0] CREDITS = 3'(DEPTH);

    logic [31:0] pc_q, pc_d;
    logic [1:0]  out_q, out_d;
    logic [1:0]  kill_q, kill_d;

    logic [31:0] rq_pc_q [2];
    logic [31:0] rq_pc_d [2];
    logic        rq_rd_q, rq_rd_d;
    logic        rq_wr_q, rq_wr_d;

    logic [31:0] iq_pc_q   [2];
    logic [31:0] iq_pc_d   [2];
    logic [31:0] iq_inst_q [2];
    logic [31:0] iq_inst_d [2];
    logic        iq_rd_q, iq_rd_d;
    logic        iq_wr_q, iq_wr_d;
    logic [1:0]  iq_cnt_q, iq_cnt_d;

    logic [31:0] d_pc_q, d_pc_d;
    logic [31:0] d_inst_q, d_inst_d;
    logic        d_valid_q, d_valid_d;

    logic        credit_ok;
    logic        accept;
    logic        rsp_live;
    logic        iq_pop;
    logic        iq_push;
    logic        bypass;
    logic [31:0] rsp_pc;
    logic        unused_jb_lsb;

    // Every in-flight fetch already owns a queue slot, so the credit covers both.
    assign credit_ok = ({1'b0, out_q} + {1'b0, iq_cnt_q}) < CREDITS;
    assign im_req    = !rst && credit_ok;
    assign im_addr   = pc_q;
    assign accept    = im_req && im_gnt;

    assign rsp_live  = im_rvalid && (kill_q == 2'd0) && !next_pc_sel;
    assign rsp_pc    = rq_pc_q[rq_rd_q];
    assign iq_pop    = !flush && !stall && (iq_cnt_q != 2'd0);
    assign bypass    = !flush && !stall && (iq_cnt_q == 2'd0) && rsp_live;
    assign iq_push   = rsp_live && !bypass;

    assign unused_jb_lsb = ^jb_pc[1:0];

    always_comb begin
        pc_d = pc_q;
        if (next_pc_sel) begin
            pc_d = {jb_pc[31:2], 2'b00};
        end else if (accept) begin
            pc_d = pc_q + 32'd4;
        end
    end

    // Kill counts the oldest in-flight responses that belong to the old path.
    always_comb begin
        out_d  = out_q + {1'b0, accept} - {1'b0, im_rvalid};
        kill_d = kill_q;
        if (next_pc_sel) begin
            kill_d = out_d;
        end else if (im_rvalid && (kill_q != 2'd0)) begin
            kill_d = kill_q - 2'd1;
        end
    end

    always_comb begin
        rq_pc_d = rq_pc_q;
        rq_rd_d = rq_rd_q;
        rq_wr_d = rq_wr_q;
        if (next_pc_sel) begin
            rq_rd_d = 1'b0;
            rq_wr_d = 1'b0;
        end else begin
            if (accept) begin
                rq_pc_d[rq_wr_q] = pc_q;
                rq_wr_d          = ~rq_wr_q;
            end
            if (rsp_live) begin
                rq_rd_d = ~rq_rd_q;
            end
        end
    end

    always_comb begin
        iq_pc_d   = iq_pc_q;
        iq_inst_d = iq_inst_q;
        iq_rd_d   = iq_rd_q;
        iq_wr_d   = iq_wr_q;
        iq_cnt_d  = iq_cnt_q + {1'b0, iq_push} - {1'b0, iq_pop};
        if (iq_pop) begin
            iq_rd_d = ~iq_rd_q;
        end
        if (iq_push) begin
            iq_pc_d[iq_wr_q]   = rsp_pc;
            iq_inst_d[iq_wr_q] = im_rdata;
            iq_wr_d            = ~iq_wr_q;
        end
        if (next_pc_sel) begin
            iq_rd_d  = 1'b0;
            iq_wr_d  = 1'b0;
            iq_cnt_d = 2'd0;
        end
    end

    // IF/ID: flush beats stall; a queued instruction always goes before a bypass.
    always_comb begin
        d_pc_d    = d_pc_q;
        d_inst_d  = d_inst_q;
        d_valid_d = d_valid_q;
        if (flush) begin
            d_inst_d  = NOP_INST;
            d_valid_d = 1'b0;
        end else if (!stall) begin
            if (iq_pop) begin
                d_pc_d    = iq_pc_q[iq_rd_q];
                d_inst_d  = iq_inst_q[iq_rd_q];
                d_valid_d = 1'b1;
            end else if (bypass) begin
                d_pc_d    = rsp_pc;
                d_inst_d  = im_rdata;
                d_valid_d = 1'b1;
            end else begin
                d_inst_d  = NOP_INST;
                d_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= {RESET_PC[31:2], 2'b00};
            out_q     <= 2'd0;
            kill_q    <= 2'd0;
            rq_pc_q   <= '{default: '0};
            rq_rd_q   <= 1'b0;
            rq_wr_q   <= 1'b0;
            iq_pc_q   <= '{default: '0};
            iq_inst_q <= '{default: '0};
            iq_rd_q   <= 1'b0;
            iq_wr_q   <= 1'b0;
            iq_cnt_q  <= 2'd0;
            d_pc_q    <= 32'd0;
            d_inst_q  <= NOP_INST;
            d_valid_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            out_q     <= out_d;
            kill_q    <= kill_d;
            rq_pc_q   <= rq_pc_d;
            rq_rd_q   <= rq_rd_d;
            rq_wr_q   <= rq_wr_d;
            iq_pc_q   <= iq_pc_d;
            iq_inst_q <= iq_inst_d;
            iq_rd_q   <= iq_rd_d;
            iq_wr_q   <= iq_wr_d;
            iq_cnt_q  <= iq_cnt_d;
            d_pc_q    <= d_pc_d;
            d_inst_q  <= d_inst_d;
            d_valid_q <= d_valid_d;
        end
    end

    assign D_pc    = d_pc_q;
    assign D_inst  = d_inst_q;
    assign D_valid = d_valid_q;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register. It consumes the execute stage's control outputs (stall, flush, next_pc_sel, jb_pc) and owns the PC. It issues in-order requests to instruction memory over a req/gnt/rvalid interface, buffers returned instructions in a 2-entry queue, and presents D_pc/D_inst/D_valid to decode. It discards in-flight fetches made stale by a redirect.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INST, 32'h0000_0013, instruction driven on D_inst for bubbles (addi x0,x0,0)
DEPTH, 2, maximum of outstanding requests plus queued instructions (fixed at 2; no other value is supported)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
stall  input  1  load-use hazard from execute; hold IF/ID
flush  input  1  squash IF/ID contents (taken branch/JAL/JALR)
next_pc_sel  input  1  redirect PC to jb_pc
jb_pc  input  32  redirect target
im_req  output  1  fetch request valid
im_addr  output  32  fetch address (word aligned)
im_gnt  input  1  request accepted this cycle
im_rvalid  input  1  response valid; responses return in request order, at least 1 cycle after grant
im_rdata  input  32  response instruction
D_pc  output  32  PC of instruction in IF/ID
D_inst  output  32  instruction in IF/ID
D_valid  output  1  IF/ID holds a real instruction

Behaviour:
- Reset (async, takes effect immediately while rst=1): pc=RESET_PC; outstanding=0; kill=0; queue empty; D_pc=0; D_inst=NOP_INST; D_valid=0. im_req=0 while rst=1.
- Credit: im_req = !rst && (outstanding + queue_count < 2). im_addr = pc (bits [1:0] always 0).
- Accept occurs when im_req && im_gnt. On accept: outstanding+1, pc pushed to the 2-entry request-PC queue, pc <= pc+4. pc wraps mod 2^32 (32'hFFFF_FFFC+4 = 0).
- While im_req=1 and im_gnt=0, im_addr is held stable, except in a redirect cycle.
- Redirect occurs when next_pc_sel=1:
  - pc <= {jb_pc[31:2],2'b00}. Redirect has priority over the +4 from a same-cycle accept.
  - kill <= outstanding count including any request accepted in the same cycle, minus any response arriving in the same cycle.
  - Request-PC queue and instruction queue are cleared.
- Response occurs when im_rvalid=1, and always sets outstanding-1. Then:
  - If kill>0, or if this is a redirect cycle: the response is dropped, and kill-1 applies when kill>0.
  - Otherwise: the response is paired with the head of the request-PC queue, that head is popped, and the pair is written to the instruction queue.
- IF/ID update, in priority order:
  - flush=1: D_inst<=NOP_INST, D_valid<=0, D_pc held. flush overrides stall.
  - stall=1: D_* held; no pop.
  - Otherwise: if the instruction queue is non-empty, D <= head and D_valid<=1, then pop. Else if an unkilled response arrives this cycle, it bypasses the queue directly into D, giving 1-cycle latency from im_rvalid to D_valid. Else D_inst<=NOP_INST, D_valid<=0, D_pc held.
- A response arriving while stalled is enqueued. The credit rule guarantees the queue never overflows. A bench assertion must fire on rvalid with queue full or with outstanding=0.
- When the queue is non-empty, ordering is strictly FIFO: the head goes to D before any bypass.
- The memory side is reset by the same rst. A response to a pre-reset request arriving after reset is illegal.

Test Plan:
1. Straight-line: reset with RESET_PC=0; memory with 1-cycle latency and always-granting returns inst=addr^32'hA5A5_0000 -> D_pc sequence 0,4,8,C on consecutive cycles after first D_valid. D_valid rises 2 cycles after rst deasserts.
2. Stall: stall=1 for 3 cycles while D_pc=8 -> D holds 8 for 3 cycles. im_req drops once outstanding+queue=2. After release, D_pc=C then 10 with no gaps or duplicates.
3. Redirect with 2 outstanding: flush=next_pc_sel=1 and jb_pc=0x100 while requests 0x10 and 0x14 are in flight -> both responses dropped; D_valid=0 with NOP_INST for that period; first valid D_pc=0x100.
4. Same-cycle events: redirect in the same cycle as a grant (addr 0x20) and an rvalid for 0x1C -> both discarded. kill ends at 1. Next im_addr=jb_pc.
5. Backpressure: im_gnt=0 for 4 cycles -> im_addr stable at 0x40. A redirect to 0x80 during that window changes im_addr to 0x80 next cycle, and nothing at 0x40 ever reaches D.
6. Async reset mid-run: assert rst between clock edges with D_valid=1 -> D_valid=0, D_inst=NOP_INST, im_req=0 immediately. PC fetch restarts at RESET_PC after release. Wrap check: pc=0xFFFF_FFFC accepted, next im_addr=0.
